wb_pipe: RTL and testbench

WB_PIPE -- requirements
Module: wb_pipe

---
 rtl/wb_pipe_if.sv | 28 ++
 rtl/wb_pipe.sv | 88 ++++++++
 tb/tb_wb_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pipe_if.sv
// wb_pipe_if: writeback-stage bundle (upstream inputs, peripheral read port, register-file write port).
interface wb_pipe_if #(
    parameter int XLEN = 32,
    parameter int RW_W = 5
);
    logic            in_valid;
    logic [4:0]      wb_ctrl;
    logic [RW_W-1:0] rw;
    logic [XLEN-1:0] ex_out;
    logic [XLEN-1:0] dm_rdata;
    logic            pr_req;
    logic [XLEN-1:0] pr_addr;
    logic [XLEN-1:0] pr_rdata;
    logic            pr_rvalid;
    logic            stall;
    logic            wb_we;
    logic [RW_W-1:0] wb_rw;
    logic [XLEN-1:0] wb_wd;
    logic            wb_err;
    modport master (
        output in_valid, wb_ctrl, rw, ex_out, dm_rdata, pr_rdata, pr_rvalid,
        input  pr_req, pr_addr, stall, wb_we, wb_rw, wb_wd, wb_err
    );
    modport slave (
        input  in_valid, wb_ctrl, rw, ex_out, dm_rdata, pr_rdata, pr_rvalid,
        output pr_req, pr_addr, stall, wb_we, wb_rw, wb_wd, wb_err
    );
endinterface

// File: rtl/wb_pipe.sv
// wb_pipe: writeback stage with load extension, data-memory/peripheral routing and a
// stalling peripheral read with timeout.
module wb_pipe #(
    parameter int          XLEN     = 32,
    parameter int          RW_W     = 5,
    parameter logic [15:0] DM_LIMIT = 16'h3000,
    parameter int          TIMEOUT  = 15
) (
    input logic     clk,
    input logic     rst,
    wb_pipe_if.slave bus
);
    typedef enum logic {IDLE, PR_WAIT} state_t;
    state_t          state, state_nxt;
    logic [7:0]      cnt;
    logic            lat_we;
    logic [2:0]      lat_fmt;
    logic [RW_W-1:0] lat_rw;
    logic            accept, mtr, mis, dm, go_pr, done_ok, is_err, pr_done, pr_to;
    logic [XLEN-1:0] result;

    // fmt = {isByte, isHalf, isSigned}; byte wins over half
    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] d, input logic [1:0] a,
                                            input logic [2:0] fmt);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = d[{a[1], 4'b0000} +: 16];
        return fmt[2] ? {{(XLEN-8){fmt[0] & b[7]}}, b}
             : fmt[1] ? {{(XLEN-16){fmt[0] & h[15]}}, h} : d;
    endfunction

    always_comb begin
        accept  = state == IDLE && bus.in_valid;
        mtr     = bus.wb_ctrl[3];
        mis     = mtr && !bus.wb_ctrl[2] &&
                  (bus.wb_ctrl[1] ? bus.ex_out[0] : bus.ex_out[1:0] != 2'b00);
        dm      = bus.ex_out[15:0] < DM_LIMIT;
        go_pr   = accept && mtr && !mis && !dm;
        done_ok = accept && !mis && (!mtr || dm);
        is_err  = accept && mis;
        pr_done = state == PR_WAIT && bus.pr_rvalid;
        pr_to   = state == PR_WAIT && !bus.pr_rvalid && cnt == 8'(TIMEOUT);
        result  = mtr ? ext(bus.dm_rdata, bus.ex_out[1:0], bus.wb_ctrl[2:0]) : bus.ex_out;
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb
        state_nxt = go_pr ? PR_WAIT : (pr_done || pr_to) ? IDLE : state;

    always_comb begin
        bus.stall  = state == PR_WAIT;
        bus.pr_req = state == PR_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_fmt     <= '0;
            lat_rw      <= '0;
            bus.pr_addr <= '0;
            bus.wb_we   <= 1'b0;
            bus.wb_err  <= 1'b0;
            bus.wb_rw   <= '0;
            bus.wb_wd   <= '0;
        end else begin
            cnt        <= state == PR_WAIT ? cnt + 8'd1 : 8'd0;
            bus.wb_we  <= done_ok ? bus.wb_ctrl[4] : pr_done && lat_we;
            bus.wb_err <= is_err || pr_to;
            if (done_ok) begin
                bus.wb_rw <= bus.rw;
                bus.wb_wd <= result;
            end else if (pr_done) begin
                bus.wb_rw <= lat_rw;
                bus.wb_wd <= ext(bus.pr_rdata, bus.pr_addr[1:0], lat_fmt);
            end
            if (go_pr) begin
                bus.pr_addr <= bus.ex_out;
                lat_we      <= bus.wb_ctrl[4];
                lat_fmt     <= bus.wb_ctrl[2:0];
                lat_rw      <= bus.rw;
            end
        end
    end
endmodule

// File: tb/tb_wb_pipe.sv
// tb_wb_pipe: directed stimulus with a queue of expected writeback events checked by a monitor.
module tb_wb_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_pipe_if #(.XLEN(32), .RW_W(5)) bus();
    wb_pipe #(.XLEN(32), .RW_W(5), .DM_LIMIT(16'h3000), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    localparam logic [4:0] ALU = 5'b10000, LB = 5'b11101, LBU = 5'b11100,
                           LH = 5'b11011, LHU = 5'b11010, LW = 5'b11000;

    typedef struct {logic err; logic [4:0] rw; logic [31:0] wd; string name;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input string name, input logic [4:0] rw, input logic [31:0] wd);
        q.push_back('{1'b0, rw, wd, name});
    endtask

    task automatic expect_err(input string name);
        q.push_back('{1'b1, 5'd0, 32'd0, name});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] c, input logic [4:0] r, input logic [31:0] ex,
                         input logic [31:0] dm);
        bus.in_valid = 1'b1;
        bus.wb_ctrl  = c;
        bus.rw       = r;
        bus.ex_out   = ex;
        bus.dm_rdata = dm;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // counts stall cycles; raises pr_rvalid in stall cycle rv_at (0 = never)
    task automatic pr_wait(input int rv_at, input logic [31:0] d, output int cycles);
        cycles = 0;
        while (bus.stall && cycles < 300) begin
            cycles++;
            bus.pr_rvalid = (cycles == rv_at);
            bus.pr_rdata  = d;
            tick();
            bus.pr_rvalid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (bus.wb_we || bus.wb_err) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got we=%0b err=%0b rw=%0d wd=0x%0h expected none",
                         bus.wb_we, bus.wb_err, bus.wb_rw, bus.wb_wd);
            end else begin
                exp_t e;
                e = q.pop_front();
                tests++;
                if (e.err ? (bus.wb_err !== 1'b1 || bus.wb_we !== 1'b0)
                          : (bus.wb_we !== 1'b1 || bus.wb_err !== 1'b0 ||
                             bus.wb_rw !== e.rw || bus.wb_wd !== e.wd)) begin
                    fails++;
                    $display("FAIL %s: got we=%0b err=%0b rw=%0d wd=0x%0h expected err=%0b rw=%0d wd=0x%0h",
                             e.name, bus.wb_we, bus.wb_err, bus.wb_rw, bus.wb_wd, e.err, e.rw, e.wd);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.wb_ctrl = '0;
        bus.rw = '0;
        bus.ex_out = '0;
        bus.dm_rdata = '0;
        bus.pr_rdata = '0;
        bus.pr_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_we", 32'(bus.wb_we), 0);
        chk("rst_err", 32'(bus.wb_err), 0);
        chk("rst_rw", 32'(bus.wb_rw), 0);
        chk("rst_wd", bus.wb_wd, 0);
        chk("rst_pr_addr", bus.pr_addr, 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_pr_req", 32'(bus.pr_req), 0);
        rst = 1'b0;

        expect_wr("alu", 7, 32'h1234_5678);
        issue(ALU, 7, 32'h1234_5678, 0);
        expect_wr("lb_signed", 1, 32'hFFFF_FF80);
        issue(LB, 1, 32'h0000_0103, 32'h80FF_7F01);
        expect_wr("lb_unsigned", 2, 32'h0000_0080);
        issue(LBU, 2, 32'h0000_0103, 32'h80FF_7F01);
        expect_wr("lh_signed", 3, 32'hFFFF_80FF);
        issue(LH, 3, 32'h0000_0102, 32'h80FF_7F01);
        expect_wr("lh_unsigned", 4, 32'h0000_7F01);
        issue(LHU, 4, 32'h0000_0100, 32'h80FF_7F01);
        expect_wr("lw_dm_below_limit", 5, 32'h80FF_7F01);
        issue(LW, 5, 32'h0001_2FFC, 32'h80FF_7F01);

        bus.pr_rvalid = 1'b1;
        tick();
        bus.pr_rvalid = 1'b0;

        expect_err("misaligned_half");
        issue(LHU, 8, 32'h0000_0101, 0);
        chk("mis_half_stall", 32'(bus.stall), 0);
        chk("mis_half_pr_req", 32'(bus.pr_req), 0);
        chk("mis_hold_rw", 32'(bus.wb_rw), 5);
        chk("mis_hold_wd", bus.wb_wd, 32'h80FF_7F01);
        expect_err("misaligned_word");
        issue(LW, 8, 32'h0000_0102, 0);

        expect_wr("pr_load", 10, 32'hDEAD_BEEF);
        issue(LW, 10, 32'h0000_7F00, 0);
        chk("pr_addr", bus.pr_addr, 32'h0000_7F00);
        chk("pr_req_high", 32'(bus.pr_req), 1);
        pr_wait(3, 32'hDEAD_BEEF, n);
        chk("pr_stall_cycles", n, 3);

        expect_wr("pr_byte_at_limit", 11, 32'h0000_00BE);
        issue(LBU, 11, 32'h0000_3001, 0);
        pr_wait(1, 32'hDEAD_BEEF, n);
        chk("pr_limit_stall_cycles", n, 1);

        expect_err("pr_timeout");
        issue(LW, 12, 32'h0000_4000, 0);
        pr_wait(0, 32'h0, n);
        chk("timeout_stall_cycles", n, 16);

        expect_wr("pr_data_on_timeout_cycle", 13, 32'hCAFE_F00D);
        issue(LW, 13, 32'h0000_4004, 0);
        pr_wait(16, 32'hCAFE_F00D, n);
        chk("late_data_stall_cycles", n, 16);

        expect_wr("pr_before_held", 14, 32'h0000_1111);
        expect_wr("held_alu", 15, 32'h0000_0055);
        issue(LW, 14, 32'h0000_8000, 0);
        bus.in_valid = 1'b1;
        bus.wb_ctrl = ALU;
        bus.rw = 15;
        bus.ex_out = 32'h55;
        pr_wait(2, 32'h0000_1111, n);
        chk("held_stall_cycles", n, 2);
        tick();
        bus.in_valid = 1'b0;

        issue(LW, 16, 32'h0000_9000, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.pr_rvalid = 1'b1;
        bus.pr_rdata = 32'h7777_7777;
        tick();
        bus.pr_rvalid = 1'b0;
        chk("abort_stall", 32'(bus.stall), 0);
        chk("abort_pr_req", 32'(bus.pr_req), 0);
        chk("abort_we", 32'(bus.wb_we), 0);
        chk("abort_err", 32'(bus.wb_err), 0);
        chk("abort_rw", 32'(bus.wb_rw), 0);
        chk("abort_wd", bus.wb_wd, 0);
        chk("abort_pr_addr", bus.pr_addr, 0);

        expect_wr("alu_after_abort", 17, 32'h0000_00A5);
        issue(ALU, 17, 32'h0000_00A5, 0);
        tick();
        tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
